// File: rtl/rom_bus_arbiter_if.sv
// Requester-side bus of the game ROM arbiter: per-slot level requests with packed
// addresses, one-cycle acks and a shared registered read-data byte.
interface rom_bus_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 17
) ();
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;   // slot i at [i*AW +: AW]
    logic [NREQ-1:0]    ack;
    logic [7:0]         rd_data;

    // Requesters (CPUs, tile/sprite fetchers) side.
    modport master (
        output req,
        output req_addr,
        input  ack,
        input  rd_data
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  req_addr,
        output ack,
        output rd_data
    );
endinterface

// File: rtl/rom_bus_arbiter.sv
// rom_bus_arbiter: shares the single-port game ROM between NREQ read requesters
// (round-robin, one read in flight) and owns the ROM write path during an HPS ioctl
// download, holding the game core off while the download runs and for one drain cycle.
// Optional build macro ARB_FIXED_PRIO_EN: fixed priority (lowest index wins), rptr held 0.
module rom_bus_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned AW      = 17,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    rom_bus_arbiter_if.slave bus,
    input  logic             ioctl_download,
    input  logic             ioctl_wr,
    input  logic [AW-1:0]    ioctl_addr,
    input  logic [7:0]       ioctl_dout,
    output logic [AW-1:0]    rom_addr,
    output logic             rom_we,
    output logic [7:0]       rom_din,
    input  logic [7:0]       rom_do,
    output logic             game_hold
);
    localparam int unsigned IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(NREQ - 1);
    localparam logic [IW:0]   NreqW   = (IW + 1)'(NREQ);
    localparam logic [1:0]    LatInit = 2'(ROM_LAT - 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StWait     = 3'd1;
    localparam logic [2:0] StCapture  = 3'd2;
    localparam logic [2:0] StDownload = 3'd3;
    localparam logic [2:0] StDrain    = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   rptr_q, rptr_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic            rom_we_q, rom_we_d;
    logic [7:0]      rom_din_q, rom_din_d;
    logic            hold_q, hold_d;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [AW-1:0]   pick_addr;

`ifdef ARB_FIXED_PRIO_EN
    // Winner selection: lowest active index wins (scan downward so it overwrites last).
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[IW'(i)]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(i);
            end
        end
    end
`else
    // Winner selection: first active slot at or above rptr, wrapping mod NREQ.
    always_comb begin
        logic [IW:0] slot;
        pick_valid = 1'b0;
        pick_idx   = '0;
        slot       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            slot = {1'b0, rptr_q} + (IW + 1)'(i);
            if (slot >= NreqW) begin
                slot = slot - NreqW;
            end
            if (bus.req[slot[IW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = slot[IW-1:0];
            end
        end
    end
`endif

    // Address mux for the selected requester.
    always_comb begin
        pick_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_addr = bus.req_addr[i*AW +: AW];
            end
        end
    end

    // Arbiter / download FSM next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        rd_data_d  = rd_data_q;
        rom_addr_d = rom_addr_q;
        rom_we_d   = 1'b0;
        rom_din_d  = rom_din_q;
        hold_d     = hold_q;
        case (state_q)
            StIdle: begin
                // Download takes precedence over any pending read request.
                if (ioctl_download) begin
                    hold_d  = 1'b1;
                    state_d = StDownload;
                end else begin
                    hold_d = 1'b0;
                    if (pick_valid) begin
                        grant_d    = pick_idx;
                        rom_addr_d = pick_addr;
                        cnt_d      = LatInit;
                        state_d    = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 2'd0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StCapture: begin
                rd_data_d      = rom_do;
                ack_d[grant_q] = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
                rptr_d = '0;
`else
                rptr_d = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
`endif
                state_d = StIdle;
            end
            StDownload: begin
                hold_d = 1'b1;
                // A write coinciding with the download falling edge is still issued.
                if (ioctl_wr) begin
                    rom_addr_d = ioctl_addr;
                    rom_din_d  = ioctl_dout;
                    rom_we_d   = 1'b1;
                end
                if (!ioctl_download) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                hold_d  = 1'b1;
                rptr_d  = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; async reset drops any outstanding read without an ack.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            ack_q      <= '0;
            rd_data_q  <= '0;
            rom_addr_q <= '0;
            rom_we_q   <= 1'b0;
            rom_din_q  <= '0;
            hold_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            rd_data_q  <= rd_data_d;
            rom_addr_q <= rom_addr_d;
            rom_we_q   <= rom_we_d;
            rom_din_q  <= rom_din_d;
            hold_q     <= hold_d;
        end
    end

    assign bus.ack     = ack_q;
    assign bus.rd_data = rd_data_q;
    assign rom_addr    = rom_addr_q;
    assign rom_we      = rom_we_q;
    assign rom_din     = rom_din_q;
    assign game_hold   = hold_q;
endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Directed bench for rom_bus_arbiter: reset, single read, round-robin order,
// back-to-back reads, download writes, download during a read, reset mid-read.
module tb_rom_bus_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 17;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [AW-1:0] ioctl_addr = '0;
    logic [7:0]    ioctl_dout = '0;
    logic [AW-1:0] rom_addr;
    logic          rom_we;
    logic [7:0]    rom_din;
    logic [7:0]    rom_do = '0;
    logic          game_hold;

    int n_tests = 0;
    int n_fail  = 0;

    rom_bus_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();

    rom_bus_arbiter #(.NREQ(NREQ), .AW(AW), .ROM_LAT(1)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .bus            (bus),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .rom_addr       (rom_addr),
        .rom_we         (rom_we),
        .rom_din        (rom_din),
        .rom_do         (rom_do),
        .game_hold      (game_hold)
    );

    always #5 clk_sys = ~clk_sys;

    // ROM contents: one marked location, otherwise low address byte xor 3C.
    function automatic logic [7:0] rom_fn(input logic [AW-1:0] a);
        if (a == 17'h01234) return 8'hA5;
        return a[7:0] ^ 8'h3C;
    endfunction

    // One-cycle-latency synchronous ROM.
    always @(posedge clk_sys) rom_do <= rom_fn(rom_addr);

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        n_tests++; if (bus.ack !== 4'b0000) begin n_fail++;
            $display("FAIL rst_ack: got %b want 0000", bus.ack); end
        n_tests++; if (bus.rd_data !== 8'h00) begin n_fail++;
            $display("FAIL rst_rd_data: got %h want 00", bus.rd_data); end
        n_tests++; if (rom_addr !== 17'h0) begin n_fail++;
            $display("FAIL rst_rom_addr: got %h want 0", rom_addr); end
        n_tests++; if (rom_we !== 1'b0) begin n_fail++;
            $display("FAIL rst_rom_we: got %b want 0", rom_we); end
        n_tests++; if (rom_din !== 8'h00) begin n_fail++;
            $display("FAIL rst_rom_din: got %h want 00", rom_din); end
        n_tests++; if (game_hold !== 1'b1) begin n_fail++;
            $display("FAIL rst_hold: got %b want 1", game_hold); end
        reset_n = 1'b1;
        #1;
        n_tests++; if (game_hold !== 1'b1) begin n_fail++;
            $display("FAIL rel_hold_now: got %b want 1", game_hold); end
        @(negedge clk_sys);
        n_tests++; if (game_hold !== 1'b0) begin n_fail++;
            $display("FAIL rel_hold_next: got %b want 0", game_hold); end
    endtask

    task automatic test_single_read();
        @(negedge clk_sys);
        bus.req_addr[1*AW +: AW] = 17'h01234;
        bus.req = 4'b0010;
        @(negedge clk_sys);
        n_tests++; if (rom_addr !== 17'h01234) begin n_fail++;
            $display("FAIL single_rom_addr: got %h want 01234", rom_addr); end
        n_tests++; if (bus.ack !== 4'b0000) begin n_fail++;
            $display("FAIL single_ack_c1: got %b want 0000", bus.ack); end
        @(negedge clk_sys);
        n_tests++; if (bus.ack !== 4'b0000) begin n_fail++;
            $display("FAIL single_ack_c2: got %b want 0000", bus.ack); end
        @(negedge clk_sys);
        n_tests++; if (bus.ack !== 4'b0010) begin n_fail++;
            $display("FAIL single_ack_c3: got %b want 0010", bus.ack); end
        n_tests++; if (bus.rd_data !== 8'hA5) begin n_fail++;
            $display("FAIL single_rd_data: got %h want a5", bus.rd_data); end
        bus.req = 4'b0000;
        @(negedge clk_sys);
        n_tests++; if (bus.ack !== 4'b0000) begin n_fail++;
            $display("FAIL single_ack_c4: got %b want 0000", bus.ack); end
    endtask

    task automatic test_round_robin();
        int exp_order [5];
`ifdef ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        // Fresh reset so the rotation starts at slot 0.
        @(negedge clk_sys);
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        for (int i = 0; i < NREQ; i++) bus.req_addr[i*AW +: AW] = 17'h00100 + AW'(i);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] want_ack;
            logic [7:0] want_data;
            want_ack  = 4'b0001 << exp_order[k];
            want_data = 8'h3C ^ 8'(exp_order[k]);
            repeat (2) begin
                @(negedge clk_sys);
                n_tests++; if (bus.ack !== 4'b0000) begin n_fail++;
                    $display("FAIL rr_gap_%0d: got %b want 0000", k, bus.ack); end
            end
            @(negedge clk_sys);
            n_tests++; if (bus.ack !== want_ack) begin n_fail++;
                $display("FAIL rr_ack_%0d: got %b want %b", k, bus.ack, want_ack); end
            n_tests++; if (bus.rd_data !== want_data) begin n_fail++;
                $display("FAIL rr_data_%0d: got %h want %h", k, bus.rd_data, want_data); end
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_back_to_back();
        @(negedge clk_sys);
        bus.req_addr[0 +: AW] = 17'h00042;
        bus.req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            repeat (2) begin
                @(negedge clk_sys);
                n_tests++; if (bus.ack !== 4'b0000) begin n_fail++;
                    $display("FAIL b2b_gap_%0d: got %b want 0000", k, bus.ack); end
            end
            @(negedge clk_sys);
            n_tests++; if (bus.ack !== 4'b0001) begin n_fail++;
                $display("FAIL b2b_ack_%0d: got %b want 0001", k, bus.ack); end
            n_tests++; if (bus.rd_data !== 8'h7E) begin n_fail++;
                $display("FAIL b2b_data_%0d: got %h want 7e", k, bus.rd_data); end
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_download();
        @(negedge clk_sys);
        // Request and download arrive together: download wins.
        bus.req_addr[0 +: AW] = 17'h00200;
        bus.req = 4'b0001;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        n_tests++; if (game_hold !== 1'b1) begin n_fail++;
            $display("FAIL dl_hold: got %b want 1", game_hold); end
        for (int k = 0; k < 4; k++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = AW'(k);
            ioctl_dout = 8'h10 + 8'(k);
            if (k == 3) ioctl_download = 1'b0;   // last write on the falling edge
            @(negedge clk_sys);
            ioctl_wr = 1'b0;
            n_tests++; if (rom_we !== 1'b1) begin n_fail++;
                $display("FAIL dl_we_%0d: got %b want 1", k, rom_we); end
            n_tests++; if (rom_addr !== AW'(k)) begin n_fail++;
                $display("FAIL dl_addr_%0d: got %h want %h", k, rom_addr, AW'(k)); end
            n_tests++; if (rom_din !== 8'h10 + 8'(k)) begin n_fail++;
                $display("FAIL dl_din_%0d: got %h want %h", k, rom_din, 8'h10 + 8'(k)); end
            n_tests++; if (bus.ack !== 4'b0000) begin n_fail++;
                $display("FAIL dl_noack_%0d: got %b want 0000", k, bus.ack); end
            @(negedge clk_sys);
            n_tests++; if (rom_we !== 1'b0) begin n_fail++;
                $display("FAIL dl_we_off_%0d: got %b want 0", k, rom_we); end
            n_tests++; if (game_hold !== 1'b1) begin n_fail++;
                $display("FAIL dl_hold_%0d: got %b want 1", k, game_hold); end
        end
        // Now in the IDLE cycle after DRAIN; the held request is picked next edge.
        @(negedge clk_sys);
        n_tests++; if (game_hold !== 1'b0) begin n_fail++;
            $display("FAIL dl_release: got %b want 0", game_hold); end
        n_tests++; if (bus.ack !== 4'b0000) begin n_fail++;
            $display("FAIL dl_post_c1: got %b want 0000", bus.ack); end
        @(negedge clk_sys);
        n_tests++; if (bus.ack !== 4'b0000) begin n_fail++;
            $display("FAIL dl_post_c2: got %b want 0000", bus.ack); end
        @(negedge clk_sys);
        n_tests++; if (bus.ack !== 4'b0001) begin n_fail++;
            $display("FAIL dl_post_ack: got %b want 0001", bus.ack); end
        n_tests++; if (bus.rd_data !== 8'h3C) begin n_fail++;
            $display("FAIL dl_post_data: got %h want 3c", bus.rd_data); end
        bus.req = 4'b0000;
    endtask

    task automatic test_download_during_read();
        @(negedge clk_sys);
        bus.req_addr[2*AW +: AW] = 17'h00305;
        bus.req = 4'b0100;
        @(negedge clk_sys);
        ioctl_download = 1'b1;   // arrives in the WAIT cycle
        @(negedge clk_sys);
        n_tests++; if (bus.ack !== 4'b0000) begin n_fail++;
            $display("FAIL dwr_ack_c2: got %b want 0000", bus.ack); end
        n_tests++; if (game_hold !== 1'b0) begin n_fail++;
            $display("FAIL dwr_hold_c2: got %b want 0", game_hold); end
        @(negedge clk_sys);
        n_tests++; if (bus.ack !== 4'b0100) begin n_fail++;
            $display("FAIL dwr_ack: got %b want 0100", bus.ack); end
        n_tests++; if (bus.rd_data !== 8'h39) begin n_fail++;
            $display("FAIL dwr_data: got %h want 39", bus.rd_data); end
        bus.req = 4'b0000;
        @(negedge clk_sys);
        n_tests++; if (game_hold !== 1'b1) begin n_fail++;
            $display("FAIL dwr_hold_dl: got %b want 1", game_hold); end
        n_tests++; if (bus.ack !== 4'b0000) begin n_fail++;
            $display("FAIL dwr_ack_dl: got %b want 0000", bus.ack); end
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sys);
        n_tests++; if (game_hold !== 1'b0) begin n_fail++;
            $display("FAIL dwr_hold_end: got %b want 0", game_hold); end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk_sys);
        bus.req_addr[3*AW +: AW] = 17'h00777;
        bus.req = 4'b1000;
        @(negedge clk_sys);
        n_tests++; if (rom_addr !== 17'h00777) begin n_fail++;
            $display("FAIL rmr_addr: got %h want 00777", rom_addr); end
        reset_n = 1'b0;
        #1;
        n_tests++; if (rom_addr !== 17'h0) begin n_fail++;
            $display("FAIL rmr_addr_rst: got %h want 0", rom_addr); end
        n_tests++; if (game_hold !== 1'b1) begin n_fail++;
            $display("FAIL rmr_hold: got %b want 1", game_hold); end
        @(negedge clk_sys);
        reset_n = 1'b1;
        bus.req = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (bus.ack !== 4'b0000) begin n_fail++;
                $display("FAIL rmr_noack_%0d: got %b want 0000", k, bus.ack); end
            @(negedge clk_sys);
        end
    endtask

    initial begin
        bus.req      = '0;
        bus.req_addr = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_back_to_back();
        test_download();
        test_download_during_read();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
